// File: rtl/color_quantizer_if.sv
// rtl/color_quantizer_if.sv - pixel in/out handshake bundle for color_quantizer
interface color_quantizer_if;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  in_r;
   logic [7:0]  in_g;
   logic [7:0]  in_b;
   logic        in_mode;
   logic        in_sof;
   logic        out_valid;
   logic        out_ready;
   logic [4:0]  out_r;
   logic [4:0]  out_g;
   logic [4:0]  out_b;
   logic        out_sof;
   logic [15:0] pix_count;

   modport master (
      output in_valid, in_r, in_g, in_b, in_mode, in_sof, out_ready,
      input  in_ready, out_valid, out_r, out_g, out_b, out_sof, pix_count
   );

   modport slave (
      input  in_valid, in_r, in_g, in_b, in_mode, in_sof, out_ready,
      output in_ready, out_valid, out_r, out_g, out_b, out_sof, pix_count
   );
endinterface

// File: rtl/color_quantizer.sv
// rtl/color_quantizer.sv - 2-stage pixel quantizer to 25-level (mode 0) or 5-bit truncated (mode 1) codes
module color_quantizer (
   input logic              clk,
   input logic              rst,
   color_quantizer_if.slave bus
);
   localparam int NLEVELS = 25;

   logic        s1_valid;
   logic        s1_mode;
   logic        s1_sof;
   logic [7:0]  s1_r;
   logic [7:0]  s1_g;
   logic [7:0]  s1_b;
   logic        s2_valid;
   logic        s2_sof;
   logic [4:0]  s2_r;
   logic [4:0]  s2_g;
   logic [4:0]  s2_b;
   logic [15:0] count;
   logic        s2_adv;
   logic        s1_load;
   logic        accept;

   // Nearest level = number of midpoints strictly below v; exact ties stay on the lower code.
   function automatic logic [4:0] quant(input logic [7:0] v, input logic mode);
      logic [4:0]  code;
      int unsigned mid2;
      code = 5'd0;
      for (int k = 1; k < NLEVELS; k++) begin
         mid2 = (85 * (k - 1)) / 8 + (85 * k) / 8;
         if (2 * {24'd0, v} > mid2) code = code + 5'd1;
      end
      if (mode) code = v[7:3];
      return code;
   endfunction

   assign s2_adv       = !s2_valid || bus.out_ready;
   assign s1_load      = !s1_valid || s2_adv;
   assign accept       = bus.in_valid && s1_load;

   assign bus.in_ready  = s1_load;
   assign bus.out_valid = s2_valid;
   assign bus.out_r     = s2_r;
   assign bus.out_g     = s2_g;
   assign bus.out_b     = s2_b;
   assign bus.out_sof   = s2_sof;
   assign bus.pix_count = count;

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_mode  <= 1'b0;
         s1_sof   <= 1'b0;
         s1_r     <= 8'd0;
         s1_g     <= 8'd0;
         s1_b     <= 8'd0;
         s2_valid <= 1'b0;
         s2_sof   <= 1'b0;
         s2_r     <= 5'd0;
         s2_g     <= 5'd0;
         s2_b     <= 5'd0;
         count    <= 16'd0;
      end else begin
         if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
               s2_r   <= quant(s1_r, s1_mode);
               s2_g   <= quant(s1_g, s1_mode);
               s2_b   <= quant(s1_b, s1_mode);
               s2_sof <= s1_sof;
            end
         end
         if (s1_load) begin
            s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
               s1_r    <= bus.in_r;
               s1_g    <= bus.in_g;
               s1_b    <= bus.in_b;
               s1_mode <= bus.in_mode;
               s1_sof  <= bus.in_sof;
            end
         end
         if (accept) begin
            if (bus.in_sof) count <= 16'd1;
            else if (count != 16'hFFFF) count <= count + 16'd1;
         end
      end
   end
endmodule

// File: tb/tb_color_quantizer.sv
// tb/tb_color_quantizer.sv - directed and streaming self-checking bench for color_quantizer
module tb_color_quantizer;
   logic clk;
   logic rst;
   int   nvec;
   int   nerr;
   int   exp_cnt [6];
   logic [7:0] cur_r;
   logic [7:0] cur_g;
   logic [7:0] cur_b;
   logic       cur_m;
   logic       cur_s;

   color_quantizer_if bus ();

   color_quantizer dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
      nvec++;
      assert (obs === req) else begin
         nerr++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, req);
      end
   endtask

   function automatic logic [4:0] model_q(input logic [7:0] v, input logic mode);
      int best;
      int bestd;
      int d;
      if (mode) return v[7:3];
      best  = 0;
      bestd = 1000;
      for (int n = 0; n < 25; n++) begin
         d = int'(v) - (85 * n) / 8;
         if (d < 0) d = -d;
         if (d < bestd) begin
            bestd = d;
            best  = n;
         end
      end
      return best[4:0];
   endfunction

   function automatic logic [15:0] out_word();
      return {bus.out_sof, bus.out_r, bus.out_g, bus.out_b};
   endfunction

   task automatic drive(input logic v, input logic [7:0] r, input logic [7:0] g,
                        input logic [7:0] b, input logic m, input logic s);
      bus.in_valid = v;
      bus.in_r     = r;
      bus.in_g     = g;
      bus.in_b     = b;
      bus.in_mode  = m;
      bus.in_sof   = s;
   endtask

   task automatic gen_pix(input int idx, input bit rnd);
      if (rnd) begin
         cur_r = 8'($urandom);
         cur_g = 8'($urandom);
         cur_b = 8'($urandom);
         cur_m = 1'($urandom);
         cur_s = ($urandom_range(7) == 0);
      end else begin
         cur_r = 8'(idx);
         cur_g = ~8'(idx);
         cur_b = 8'(idx) ^ 8'h5a;
         cur_m = (idx >= 256);
         cur_s = ((idx % 256) == 0);
      end
   endtask

   task automatic run_stream(input int npix, input bit rnd);
      logic [16:0] expq [$];
      logic [16:0] e;
      logic [15:0] obs;
      logic [15:0] held;
      bit          stalled;
      int          sent;
      int          popped;
      int          cycles;
      sent    = 0;
      popped  = 0;
      cycles  = 0;
      stalled = 1'b0;
      held    = 16'd0;
      gen_pix(0, rnd);
      while (popped < npix && cycles < npix * 8 + 100) begin
         @(negedge clk);
         cycles++;
         if (sent < npix && (!rnd || $urandom_range(3) != 0))
            drive(1'b1, cur_r, cur_g, cur_b, cur_m, cur_s);
         else
            drive(1'b0, cur_r, cur_g, cur_b, cur_m, cur_s);
         bus.out_ready = rnd ? ($urandom_range(2) != 0) : 1'b1;
         #1;
         obs = out_word();
         if (stalled) begin
            chk("stall_valid", 32'(bus.out_valid), 32'd1);
            chk("stall_hold", 32'(obs), 32'(held));
         end
         if (bus.in_valid && bus.in_ready) begin
            expq.push_back({cur_m, cur_s, model_q(cur_r, cur_m), model_q(cur_g, cur_m),
                            model_q(cur_b, cur_m)});
            sent++;
            gen_pix(sent, rnd);
         end
         if (bus.out_valid && bus.out_ready) begin
            if (expq.size() == 0) begin
               chk("extra_pixel", 32'(expq.size()), 32'd1);
            end else begin
               e = expq.pop_front();
               chk("pixel", 32'(obs), 32'(e[15:0]));
               if (!e[16])
                  chk("mode0_max", 32'(bus.out_r <= 5'd24 && bus.out_g <= 5'd24 &&
                                       bus.out_b <= 5'd24), 32'd1);
            end
            popped++;
         end
         stalled = bus.out_valid && !bus.out_ready;
         held    = obs;
      end
      chk("stream_done", 32'(popped), 32'(npix));
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      repeat (3) @(negedge clk);
      #1 chk("stream_drained", 32'(bus.out_valid), 32'd0);
   endtask

   initial begin
      nvec = 0;
      nerr = 0;
      exp_cnt = '{1, 2, 3, 4, 5, 1};

      // Reset with a pixel presented: it must be neither accepted nor counted.
      rst = 1'b1;
      bus.out_ready = 1'b1;
      drive(1'b1, 8'd200, 8'd100, 8'd50, 1'b0, 1'b1);
      repeat (2) @(negedge clk);
      #1;
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_out_data", 32'(out_word()), 32'd0);
      chk("rst_pix_count", 32'(bus.pix_count), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      drive(1'b0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0);
      #1 chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
      @(negedge clk);
      #1 chk("post_rst_count", 32'(bus.pix_count), 32'd0);
      @(negedge clk);
      #1 chk("post_rst_no_out", 32'(bus.out_valid), 32'd0);

      // Two-cycle latency, 5 ties down to 0.
      @(negedge clk);
      drive(1'b1, 8'd0, 8'd5, 8'd6, 1'b0, 1'b1);
      #1 chk("lat_in_ready", 32'(bus.in_ready), 32'd1);
      @(negedge clk);
      drive(1'b0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0);
      #1;
      chk("lat_c1_valid", 32'(bus.out_valid), 32'd0);
      chk("lat_count", 32'(bus.pix_count), 32'd1);
      @(negedge clk);
      #1;
      chk("lat_c2_valid", 32'(bus.out_valid), 32'd1);
      chk("lat_c2_data", 32'(out_word()), 32'({1'b1, 5'd0, 5'd0, 5'd1}));
      @(negedge clk);
      #1 chk("lat_c3_empty", 32'(bus.out_valid), 32'd0);

      // Back-to-back pixels with a mode switch between them.
      @(negedge clk);
      drive(1'b1, 8'd128, 8'd249, 8'd255, 1'b0, 1'b0);
      @(negedge clk);
      drive(1'b1, 8'd255, 8'd8, 8'd7, 1'b1, 1'b0);
      #1 chk("b2b_in_ready", 32'(bus.in_ready), 32'd1);
      @(negedge clk);
      drive(1'b0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0);
      #1;
      chk("b2b_first_valid", 32'(bus.out_valid), 32'd1);
      chk("b2b_mode0", 32'(out_word()), 32'({1'b0, 5'd12, 5'd23, 5'd24}));
      @(negedge clk);
      #1;
      chk("b2b_second_valid", 32'(bus.out_valid), 32'd1);
      chk("b2b_mode1", 32'(out_word()), 32'({1'b0, 5'd31, 5'd1, 5'd0}));
      chk("b2b_count", 32'(bus.pix_count), 32'd3);
      @(negedge clk);
      #1 chk("b2b_empty", 32'(bus.out_valid), 32'd0);

      // sof restarts the per-frame count.
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         if (i < 6) drive(1'b1, 8'(i), 8'(i), 8'(i), 1'b0, (i == 0 || i == 5));
         else       drive(1'b0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0);
         #1;
         if (i > 0) chk("sof_count", 32'(bus.pix_count), 32'(exp_cnt[i-1]));
      end
      repeat (3) @(negedge clk);

      // Reset with two pixels in flight.
      @(negedge clk);
      drive(1'b1, 8'd10, 8'd20, 8'd30, 1'b0, 1'b1);
      @(negedge clk);
      drive(1'b1, 8'd40, 8'd50, 8'd60, 1'b1, 1'b0);
      @(negedge clk);
      drive(1'b0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0);
      rst = 1'b1;
      #1 chk("inflight_pre_valid", 32'(bus.out_valid), 32'd1);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("inflight_rst_valid", 32'(bus.out_valid), 32'd0);
      chk("inflight_rst_count", 32'(bus.pix_count), 32'd0);
      chk("inflight_rst_data", 32'(out_word()), 32'd0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         #1 chk("inflight_no_stale", 32'(bus.out_valid), 32'd0);
      end

      run_stream(512, 1'b0);
      run_stream(1000, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
